// File: rtl/cpu6502_interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// cpu6502_interrupt_sequencer
//
// Sequences reset, NMI, IRQ and BRK entry for the 6502 core. It owns the bus
// for a 7-cycle entry sequence: two dummy PC reads, three stack pushes (PCH,
// PCL, P) and two vector reads. It then hands the vector to the program
// counter. The core muxes busAddress/busDataOut/busWrite onto the bus while
// active=1.
//
// Optional feature macro: CPU6502_NMI_HIJACK_EN
//   defined   : an NMI that becomes pending before the vector-low read of an
//               IRQ/BRK sequence steals that sequence's vector (NMI_VECTOR).
//   undefined : the vector is fixed at start; the NMI waits for the next
//               instruction boundary.
//
// Ports
//   clock, cpuReset (sync, active-high), cpuClockEnable (cycle strobe)
//   nmiN (edge, active-low), irqN (level, active-low), irqDisable (I flag)
//   instructionBoundary, brkStart        : start qualifiers from the decoder
//   programCounter, stackPointer, statusIn, dataIn : core state / read bus
//   busAddress, busDataOut, busWrite, active       : bus ownership outputs
//   spDecrement, setIrqDisable, pcLoad, pcLoadValue: core update strobes
// ---------------------------------------------------------------------------
module cpu6502_interrupt_sequencer #(
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
  input  logic        clock,
  input  logic        cpuReset,
  input  logic        cpuClockEnable,
  input  logic        nmiN,
  input  logic        irqN,
  input  logic        irqDisable,
  input  logic        instructionBoundary,
  input  logic        brkStart,
  input  logic [15:0] programCounter,
  input  logic [7:0]  stackPointer,
  input  logic [7:0]  statusIn,
  input  logic [7:0]  dataIn,
  output logic [15:0] busAddress,
  output logic [7:0]  busDataOut,
  output logic        busWrite,
  output logic        active,
  output logic        spDecrement,
  output logic        setIrqDisable,
  output logic        pcLoad,
  output logic [15:0] pcLoadValue
);

`ifdef CPU6502_NMI_HIJACK_EN
  localparam logic HIJACK_EN = 1'b1;
`else
  localparam logic HIJACK_EN = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S0   = 3'd1;
  localparam logic [2:0] ST_S1   = 3'd2;
  localparam logic [2:0] ST_S2   = 3'd3;
  localparam logic [2:0] ST_S3   = 3'd4;
  localparam logic [2:0] ST_S4   = 3'd5;
  localparam logic [2:0] ST_S5   = 3'd6;
  localparam logic [2:0] ST_S6   = 3'd7;

  logic [2:0]  state_q, state_d;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic        rst_seq_q, rst_seq_d;
  logic        brk_seq_q, brk_seq_d;
  logic [15:0] vector_q, vector_d;
  logic [15:0] push_pc_q, push_pc_d;
  logic [7:0]  vec_lo_q, vec_lo_d;

  logic        nmi_edge;
  logic        nmi_clr;
  logic [7:0]  push_p;

  // Next-state logic: everything advances only on enabled cycles.
  always_comb begin
    state_d    = state_q;
    rst_pend_d = rst_pend_q;
    nmi_prev_d = nmi_prev_q;
    rst_seq_d  = rst_seq_q;
    brk_seq_d  = brk_seq_q;
    vector_d   = vector_q;
    push_pc_d  = push_pc_q;
    vec_lo_d   = vec_lo_q;
    nmi_clr    = 1'b0;
    nmi_edge   = cpuClockEnable & nmi_prev_q & ~nmiN;

    if (cpuClockEnable) begin
      nmi_prev_d = nmiN;
      case (state_q)
        ST_IDLE: begin
          if (rst_pend_q) begin
            state_d = ST_S0; vector_d = RESET_VECTOR; rst_seq_d = 1'b1; brk_seq_d = 1'b0;
          end else if (instructionBoundary && nmi_pend_q) begin
            state_d = ST_S0; vector_d = NMI_VECTOR; rst_seq_d = 1'b0; brk_seq_d = 1'b0;
            nmi_clr = 1'b1;
          end else if (instructionBoundary && !irqN && !irqDisable) begin
            state_d = ST_S0; vector_d = IRQ_VECTOR; rst_seq_d = 1'b0; brk_seq_d = 1'b0;
          end else if (brkStart) begin
            state_d = ST_S0; vector_d = IRQ_VECTOR; rst_seq_d = 1'b0; brk_seq_d = 1'b1;
          end
        end
        ST_S6: begin
          state_d = ST_IDLE;
          if (rst_seq_q) rst_pend_d = 1'b0;
        end
        default: state_d = state_q + 3'd1;
      endcase

      if (state_q == ST_S1) push_pc_d = programCounter;
      if (state_q == ST_S5) vec_lo_d  = dataIn;

      // Late NMI steals an IRQ/BRK sequence while the vector is still unread.
      if (HIJACK_EN && nmi_pend_q && !rst_seq_q && (vector_q == IRQ_VECTOR) &&
          (state_q >= ST_S0) && (state_q <= ST_S4)) begin
        vector_d = NMI_VECTOR;
        nmi_clr  = 1'b1;
      end
    end

    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
  end

  // Pushed P always has bit5 set; bit4 (B) distinguishes BRK from IRQ/NMI.
  assign push_p = ((statusIn | 8'h20) & 8'hEF) | (brk_seq_q ? 8'h10 : 8'h00);

  // Bus outputs are decoded from the current state; reset forces them idle.
  always_comb begin
    busAddress    = programCounter;
    busDataOut    = 8'h00;
    busWrite      = 1'b0;
    active        = 1'b0;
    spDecrement   = 1'b0;
    setIrqDisable = 1'b0;
    pcLoad        = 1'b0;
    pcLoadValue   = 16'h0000;
    if (!cpuReset && (state_q != ST_IDLE)) begin
      active = 1'b1;
      case (state_q)
        ST_S2, ST_S3, ST_S4: begin
          busAddress  = {STACK_PAGE, stackPointer};
          spDecrement = 1'b1;
          // Reset walks the stack without writing it.
          busWrite    = ~rst_seq_q;
          if (!rst_seq_q) begin
            case (state_q)
              ST_S2:   busDataOut = push_pc_q[15:8];
              ST_S3:   busDataOut = push_pc_q[7:0];
              default: busDataOut = push_p;
            endcase
          end
        end
        ST_S5: begin
          busAddress    = vector_q;
          setIrqDisable = 1'b1;
        end
        ST_S6: begin
          busAddress  = vector_q + 16'd1;
          pcLoad      = 1'b1;
          pcLoadValue = {dataIn, vec_lo_q};
        end
        default: busAddress = programCounter;
      endcase
    end
  end

  // Registers: control state reset, datapath latches free-running.
  always_ff @(posedge clock) begin
    if (cpuReset) begin
      state_q    <= ST_IDLE;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= nmiN;
      rst_seq_q  <= 1'b0;
      brk_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
      rst_seq_q  <= rst_seq_d;
      brk_seq_q  <= brk_seq_d;
    end
    vector_q  <= vector_d;
    push_pc_q <= push_pc_d;
    vec_lo_q  <= vec_lo_d;
  end

endmodule

// File: tb/tb_cpu6502_interrupt_sequencer.sv
module tb_cpu6502_interrupt_sequencer;

`ifdef CPU6502_NMI_HIJACK_EN
  localparam bit HIJACK = 1'b1;
`else
  localparam bit HIJACK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        cpuReset, cpuClockEnable, nmiN, irqN, irqDisable;
  logic        instructionBoundary, brkStart;
  logic [15:0] programCounter;
  logic [7:0]  stackPointer, statusIn, dataIn;
  logic [15:0] busAddress, pcLoadValue;
  logic [7:0]  busDataOut;
  logic        busWrite, active, spDecrement, setIrqDisable, pcLoad;

  always #5 clock = ~clock;

  cpu6502_interrupt_sequencer dut (
    .clock(clock), .cpuReset(cpuReset), .cpuClockEnable(cpuClockEnable),
    .nmiN(nmiN), .irqN(irqN), .irqDisable(irqDisable),
    .instructionBoundary(instructionBoundary), .brkStart(brkStart),
    .programCounter(programCounter), .stackPointer(stackPointer),
    .statusIn(statusIn), .dataIn(dataIn),
    .busAddress(busAddress), .busDataOut(busDataOut), .busWrite(busWrite),
    .active(active), .spDecrement(spDecrement), .setIrqDisable(setIrqDisable),
    .pcLoad(pcLoad), .pcLoadValue(pcLoadValue)
  );

  // Memory image seen on dataIn.
  function automatic logic [7:0] memrd(input logic [15:0] a);
    case (a)
      16'hFFFA: memrd = 8'h00;
      16'hFFFB: memrd = 8'h90;
      16'hFFFC: memrd = 8'h00;
      16'hFFFD: memrd = 8'h80;
      16'hFFFE: memrd = 8'h00;
      16'hFFFF: memrd = 8'hA0;
      default:  memrd = a[7:0] ^ 8'h5A;
    endcase
  endfunction
  assign dataIn = memrd(busAddress);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending flags plus a position in the 7-cycle entry table.
  bit          m_rst_pend, m_nmi_pend, m_nmi_prev, m_rst, m_brk;
  int          m_pos = 7;            // 7 = idle, 0..6 = entry cycle index
  logic [15:0] m_vec, m_pc;
  logic [7:0]  m_sp0, m_p;

  // Logs of what the bus did on enabled cycles.
  logic [23:0] wr_log[$];
  logic [15:0] sp_log[$];
  logic [15:0] sei_addr, last_load;
  int          load_cnt = 0, act_cnt = 0;
  bit          dec_pend;
  int          ce_mode = 0;          // 0 always on, 1 alternating, 2 manual

  task automatic model_start(input bit rst, input bit brk, input logic [15:0] vec);
    m_pos = 0; m_rst = rst; m_brk = brk; m_vec = vec;
    m_pc = programCounter; m_sp0 = stackPointer; m_p = statusIn;
  endtask

  task automatic compare_and_step();
    logic        e_act, e_wr, e_spd, e_sei, e_pcl, edge_s, clr;
    logic [15:0] e_addr, e_pclv;
    logic [7:0]  e_data, off;
    e_act = 0; e_wr = 0; e_spd = 0; e_sei = 0; e_pcl = 0;
    e_addr = programCounter; e_pclv = 16'h0; e_data = 8'h0;
    if (!cpuReset && m_pos < 7) begin
      e_act = 1;
      off = 8'(m_pos) - 8'd2;
      if (m_pos >= 2 && m_pos <= 4) begin
        e_addr = {8'h01, m_sp0 - off};
        e_spd = 1; e_wr = !m_rst;
        if (!m_rst)
          e_data = (m_pos == 2) ? m_pc[15:8] : (m_pos == 3) ? m_pc[7:0]
                 : (((m_p | 8'h20) & 8'hEF) | (m_brk ? 8'h10 : 8'h00));
      end else if (m_pos == 5) begin
        e_addr = m_vec; e_sei = 1;
      end else if (m_pos == 6) begin
        e_addr = m_vec + 16'd1; e_pcl = 1;
        e_pclv = {memrd(m_vec + 16'd1), memrd(m_vec)};
      end
    end
    chk("active", {31'd0, active}, {31'd0, e_act});
    chk("busAddress", {16'd0, busAddress}, {16'd0, e_addr});
    chk("busDataOut", {24'd0, busDataOut}, {24'd0, e_data});
    chk("busWrite", {31'd0, busWrite}, {31'd0, e_wr});
    chk("spDecrement", {31'd0, spDecrement}, {31'd0, e_spd});
    chk("setIrqDisable", {31'd0, setIrqDisable}, {31'd0, e_sei});
    chk("pcLoad", {31'd0, pcLoad}, {31'd0, e_pcl});
    chk("pcLoadValue", {16'd0, pcLoadValue}, {16'd0, e_pclv});

    dec_pend = cpuClockEnable && spDecrement && !cpuReset;
    if (cpuClockEnable && !cpuReset) begin
      if (busWrite) wr_log.push_back({busAddress, busDataOut});
      if (spDecrement) sp_log.push_back(busAddress);
      if (setIrqDisable) sei_addr = busAddress;
      if (pcLoad) begin last_load = pcLoadValue; load_cnt++; end
      if (active) act_cnt++;
    end

    if (cpuReset) begin
      m_pos = 7; m_rst_pend = 1; m_nmi_pend = 0; m_nmi_prev = nmiN;
    end else if (cpuClockEnable) begin
      edge_s = m_nmi_prev && !nmiN;
      clr = 0;
      if (m_pos == 7) begin
        if (m_rst_pend) model_start(1, 0, 16'hFFFC);
        else if (instructionBoundary && m_nmi_pend) begin
          model_start(0, 0, 16'hFFFA); clr = 1;
        end else if (instructionBoundary && !irqN && !irqDisable) model_start(0, 0, 16'hFFFE);
        else if (brkStart) model_start(0, 1, 16'hFFFE);
      end else begin
        if (HIJACK && m_pos <= 4 && m_nmi_pend && !m_rst && m_vec == 16'hFFFE) begin
          m_vec = 16'hFFFA; clr = 1;
        end
        if (m_pos == 6 && m_rst) m_rst_pend = 0;
        m_pos++;
      end
      m_nmi_pend = (m_nmi_pend && !clr) || edge_s;
      m_nmi_prev = nmiN;
    end
  endtask

  // One CPU clock: check at the falling edge, then let the core react.
  task automatic tick();
    @(negedge clock);
    compare_and_step();
    @(posedge clock);
    #1;
    if (dec_pend) stackPointer = stackPointer - 8'd1;
    if (ce_mode == 1) cpuClockEnable = ~cpuClockEnable;
    else if (ce_mode == 0) cpuClockEnable = 1'b1;
  endtask

  task automatic wait_load(input string name, input int budget);
    int start;
    bit seen;
    start = load_cnt; seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (load_cnt > start) begin seen = 1; break; end
    end
    chk({name, "_load_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (wr_log.size() >= n) begin seen = 1; break; end
      tick();
    end
    chk({name, "_writes_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic irq_pulse();
    irqN = 0; instructionBoundary = 1;
    tick();
    instructionBoundary = 0; irqN = 1;
  endtask

  initial begin
    int n;
    cpuReset = 1; cpuClockEnable = 1; nmiN = 1; irqN = 1; irqDisable = 0;
    instructionBoundary = 0; brkStart = 0; programCounter = 16'h0400;
    stackPointer = 8'hFD; statusIn = 8'h00;
    repeat (3) tick();
    chk("reset_active", {31'd0, active}, 32'd0);
    chk("reset_addr", {16'd0, busAddress}, 32'h0400);

    // 1: reset sequence with an irregular clock enable.
    ce_mode = 1; cpuReset = 0;
    wait_load("t1", 40);
    ce_mode = 0; cpuClockEnable = 1;
    chk("t1_sp_count", sp_log.size(), 3);
    if (sp_log.size() == 3) begin
      chk("t1_sp0", {16'd0, sp_log[0]}, 32'h01FD);
      chk("t1_sp1", {16'd0, sp_log[1]}, 32'h01FC);
      chk("t1_sp2", {16'd0, sp_log[2]}, 32'h01FB);
    end
    chk("t1_no_writes", wr_log.size(), 0);
    chk("t1_vector", {16'd0, last_load}, 32'h8000);
    tick();

    // 2: IRQ entry, IRQ released right after the decision.
    wr_log.delete(); stackPointer = 8'hFF; programCounter = 16'h1234; statusIn = 8'h00;
    irq_pulse();
    wait_load("t2", 20);
    chk("t2_write_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t2_push_pch", {8'd0, wr_log[0]}, 32'h01FF12);
      chk("t2_push_pcl", {8'd0, wr_log[1]}, 32'h01FE34);
      chk("t2_push_p", {8'd0, wr_log[2]}, 32'h01FD20);
    end
    chk("t2_sei_addr", {16'd0, sei_addr}, 32'hFFFE);
    chk("t2_vector", {16'd0, last_load}, 32'hA000);
    tick();

    // 3: masked IRQ ignored; NMI edge taken at the next boundary.
    wr_log.delete(); stackPointer = 8'hFF; statusIn = 8'hC3;
    n = act_cnt;
    irqN = 0; irqDisable = 1; instructionBoundary = 1;
    repeat (5) tick();
    chk("t3_masked_idle", act_cnt, n);
    instructionBoundary = 0; nmiN = 0;
    repeat (2) tick();
    chk("t3_wait_boundary", act_cnt, n);
    instructionBoundary = 1;
    tick();
    instructionBoundary = 0;
    wait_load("t3", 20);
    chk("t3_vector", {16'd0, last_load}, 32'h9000);
    if (wr_log.size() == 3) chk("t3_push_p", {24'd0, wr_log[2][7:0]}, 32'hE3);
    nmiN = 1; irqN = 1; irqDisable = 0;
    tick();

    // 4: BRK entry.
    wr_log.delete(); stackPointer = 8'hFF; programCounter = 16'h2002; statusIn = 8'h01;
    sei_addr = 16'h0;
    brkStart = 1;
    tick();
    brkStart = 0;
    wait_load("t4", 20);
    chk("t4_write_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t4_push_pch", {24'd0, wr_log[0][7:0]}, 32'h20);
      chk("t4_push_pcl", {24'd0, wr_log[1][7:0]}, 32'h02);
      chk("t4_push_p", {24'd0, wr_log[2][7:0]}, 32'h31);
    end
    chk("t4_sei_addr", {16'd0, sei_addr}, 32'hFFFE);
    chk("t4_vector", {16'd0, last_load}, 32'hA000);
    tick();

    // 5: NMI edge while PCL is being pushed during an IRQ.
    wr_log.delete(); stackPointer = 8'hFF; programCounter = 16'h5678; statusIn = 8'h00;
    irq_pulse();
    wait_writes("t5", 1, 10);
    nmiN = 0;
    wait_load("t5", 20);
    n = load_cnt;
    if (HIJACK) begin
      chk("t5_hijack_vector", {16'd0, last_load}, 32'h9000);
      instructionBoundary = 1;
      repeat (4) tick();
      instructionBoundary = 0;
      chk("t5_no_second_nmi", load_cnt, n);
    end else begin
      chk("t5_fixed_vector", {16'd0, last_load}, 32'hA000);
      instructionBoundary = 1;
      tick();
      instructionBoundary = 0;
      wait_load("t5_nmi", 20);
      chk("t5_late_nmi_vector", {16'd0, last_load}, 32'h9000);
    end
    nmiN = 1;
    tick();

    // 6: reset lands mid-push with a toggling enable.
    wr_log.delete(); stackPointer = 8'hFF;
    irq_pulse();
    wait_writes("t6", 1, 10);
    ce_mode = 2; cpuReset = 1; cpuClockEnable = 1;
    #1;
    chk("t6_reset_no_write", {31'd0, busWrite}, 32'd0);
    chk("t6_reset_inactive", {31'd0, active}, 32'd0);
    tick(); cpuClockEnable = 0;
    tick(); cpuClockEnable = 1;
    tick();
    cpuReset = 0; ce_mode = 0;
    n = wr_log.size();
    wait_load("t6", 20);
    chk("t6_no_writes", wr_log.size(), n);
    chk("t6_vector", {16'd0, last_load}, 32'h8000);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
